// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_core_if : receive-side delivery bundle (byte handshake, error pulses)
// Revision 1.0
// ---------------------------------------------------------------------------
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    output frame_err,
    output parity_err,
    output overrun,
    output busy
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    input  frame_err,
    input  parity_err,
    input  overrun,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_core : UART receiver, mid-bit sampling, 1-entry valid/ready holding register
// Revision 1.0
// ---------------------------------------------------------------------------
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  input  wire logic      rxd,
  uart_rx_core_if.master rx_if
);

  localparam int                   DIV_W    = $clog2(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0]     DIV_HALF = DIV_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DIV_W-1:0]     DIV_FULL = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DATA_BITS-1:0] BIT_LAST = DATA_BITS'(DATA_BITS - 1);
  localparam logic                 HAS_PAR  = (PARITY_EN != 0);
  localparam logic                 PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } state_t;

  state_t               state, state_nx;
  logic                 sync1, rxd_s;
  logic [DIV_W-1:0]     div_cnt, div_nx;
  logic [DATA_BITS-1:0] bit_cnt, bit_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic                 par_bad, par_bad_nx;
  logic [DATA_BITS-1:0] data_q, data_nx;
  logic                 valid_q, valid_nx;
  logic                 fe_q, fe_nx;
  logic                 pe_q, pe_nx;
  logic                 ov_q, ov_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxd_s <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    div_nx     = div_cnt;
    bit_nx     = bit_cnt;
    shift_nx   = shift;
    par_bad_nx = par_bad;
    data_nx    = data_q;
    // a transfer empties the register unless a new byte reloads it below
    valid_nx   = valid_q & ~rx_if.rx_ready;
    fe_nx      = 1'b0;
    pe_nx      = 1'b0;
    ov_nx      = 1'b0;

    case (state)
      IDLE: begin
        div_nx     = '0;
        bit_nx     = '0;
        par_bad_nx = 1'b0;
        if (!rxd_s) begin
          state_nx = START;
        end
      end

      START: begin
        if (div_cnt == DIV_HALF) begin
          div_nx   = '0;
          state_nx = rxd_s ? IDLE : DATA;
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end

      DATA: begin
        if (div_cnt == DIV_FULL) begin
          div_nx   = '0;
          shift_nx = {rxd_s, shift[DATA_BITS-1:1]};
          if (bit_cnt == BIT_LAST) begin
            bit_nx   = '0;
            state_nx = HAS_PAR ? PARITY : STOP;
          end else begin
            bit_nx = bit_cnt + 1'b1;
          end
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end

      PARITY: begin
        if (div_cnt == DIV_FULL) begin
          div_nx     = '0;
          par_bad_nx = (rxd_s != ((^shift) ^ PAR_ODD));
          state_nx   = STOP;
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end

      STOP: begin
        if (div_cnt == DIV_FULL) begin
          div_nx   = '0;
          fe_nx    = ~rxd_s;
          pe_nx    = par_bad;
          state_nx = rxd_s ? IDLE : BRK;
          if (rxd_s && !par_bad) begin
            if (valid_q && !rx_if.rx_ready) begin
              ov_nx = 1'b1;
            end else begin
              data_nx  = shift;
              valid_nx = 1'b1;
            end
          end
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end

      // line held low past the stop bit: wait for idle before re-arming
      BRK: begin
        if (rxd_s) begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bad <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      div_cnt <= div_nx;
      bit_cnt <= bit_nx;
      shift   <= shift_nx;
      par_bad <= par_bad_nx;
      data_q  <= data_nx;
      valid_q <= valid_nx;
      fe_q    <= fe_nx;
      pe_q    <= pe_nx;
      ov_q    <= ov_nx;
    end
  end

  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.frame_err  = fe_q;
  assign rx_if.parity_err = pe_q;
  assign rx_if.overrun    = ov_q;
  assign rx_if.busy       = (state != IDLE);

endmodule
`default_nettype wire
